// File: rtl/proc6_pkg.sv
// proc6 shared definitions: opcodes, controller states and
// instruction field positions.
package proc6_pkg;

   typedef enum logic [3:0] {
      OP_LOAD  = 4'd0,
      OP_STORE = 4'd1,
      OP_ADD   = 4'd2,
      OP_MOVI  = 4'd3,
      OP_SUB   = 4'd4,
      OP_JMPZ  = 4'd5,
      OP_HALT  = 4'd6
   } op_e;

   typedef enum logic [3:0] {
      S_IDLE,
      S_FETCH,
      S_DECODE,
      S_LOAD,
      S_STORE,
      S_ADD,
      S_MOVI,
      S_SUB,
      S_JMPZ,
      S_JMP,
      S_HALT
   } state_e;

   localparam int OP_HI  = 15;
   localparam int OP_LO  = 12;
   localparam int RA_HI  = 11;
   localparam int RA_LO  = 8;
   localparam int RB_HI  = 7;
   localparam int RB_LO  = 4;
   localparam int RC_HI  = 3;
   localparam int RC_LO  = 0;
   localparam int IMM_HI = 7;
   localparam int IMM_LO = 0;

endpackage

// File: rtl/proc6_ctrl.sv
// proc6 controller: multi-cycle fetch/decode/execute FSM and
// the sticky illegal-opcode flag.
module proc6_ctrl
   import proc6_pkg::*;
(
   input  logic       clk,
   input  logic       i_reset,
   input  logic       i_start,
   input  logic [3:0] i_op,
   input  logic       i_zero,
   output logic       o_pc_clr,
   output logic       o_fetch,
   output logic       o_jmp,
   output logic       o_rf_we,
   output logic       o_sel_mem,
   output logic       o_sel_imm,
   output logic       o_alu_sub,
   output logic       o_alu_rb,
   output logic       o_d_rd,
   output logic       o_d_wr,
   output logic       o_retire,
   output logic       o_halted,
   output logic       o_err
);

   state_e r_state;
   state_e w_next;
   logic   r_err;
   logic   w_launch;
   logic   w_illegal;

   assign w_launch  = i_start &&
                      (r_state == S_IDLE || r_state == S_HALT);
   assign w_illegal = i_op > OP_HALT;
   assign o_pc_clr  = w_launch;
   assign o_err     = r_err;

   // state register
   always_ff @(posedge clk) begin
      if (i_reset) r_state <= S_IDLE;
      else         r_state <= w_next;
   end

   // err is cleared on launch, set when decode hits an illegal opcode
   always_ff @(posedge clk) begin
      if (i_reset)
         r_err <= 1'b0;
      else if (w_launch)
         r_err <= 1'b0;
      else if (r_state == S_DECODE && w_illegal)
         r_err <= 1'b1;
   end

   // next-state selection
   always_comb begin
      w_next = r_state;
      unique case (r_state)
         S_IDLE, S_HALT: if (i_start) w_next = S_FETCH;
         S_FETCH:        w_next = S_DECODE;
         S_DECODE: begin
            case (i_op)
               OP_LOAD:  w_next = S_LOAD;
               OP_STORE: w_next = S_STORE;
               OP_ADD:   w_next = S_ADD;
               OP_MOVI:  w_next = S_MOVI;
               OP_SUB:   w_next = S_SUB;
               OP_JMPZ:  w_next = S_JMPZ;
               default:  w_next = S_HALT;
            endcase
         end
         S_JMPZ:  w_next = i_zero ? S_JMP : S_FETCH;
         default: w_next = S_FETCH;
      endcase
   end

   // per-state datapath strobes; memory strobes are masked by reset
   always_comb begin
      o_fetch   = 1'b0;
      o_jmp     = 1'b0;
      o_rf_we   = 1'b0;
      o_sel_mem = 1'b0;
      o_sel_imm = 1'b0;
      o_alu_sub = 1'b0;
      o_alu_rb  = 1'b0;
      o_d_rd    = 1'b0;
      o_d_wr    = 1'b0;
      o_retire  = 1'b0;
      o_halted  = 1'b0;
      unique case (r_state)
         S_FETCH: o_fetch = 1'b1;
         S_LOAD: begin
            o_rf_we   = 1'b1;
            o_sel_mem = 1'b1;
            o_d_rd    = !i_reset;
            o_retire  = 1'b1;
         end
         S_STORE: begin
            o_d_wr   = !i_reset;
            o_retire = 1'b1;
         end
         S_ADD: begin
            o_rf_we  = 1'b1;
            o_alu_rb = 1'b1;
            o_retire = 1'b1;
         end
         S_MOVI: begin
            o_rf_we   = 1'b1;
            o_sel_imm = 1'b1;
            o_retire  = 1'b1;
         end
         S_SUB: begin
            o_rf_we   = 1'b1;
            o_alu_rb  = 1'b1;
            o_alu_sub = 1'b1;
            o_retire  = 1'b1;
         end
         S_JMPZ: o_retire = !i_zero;
         S_JMP: begin
            o_jmp    = 1'b1;
            o_retire = 1'b1;
         end
         S_HALT:  o_halted = 1'b1;
         default: ;
      endcase
   end

endmodule

// File: rtl/proc6_core.sv
// proc6 top: PC, IR, 16-entry register file and ALU, driven by
// the proc6_ctrl FSM.
module proc6_core
   import proc6_pkg::*;
#(
   parameter int WIDTH  = 16,
   parameter int PCBITS = 16,
   parameter int DADDR  = 8
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              start,
   output logic [PCBITS-1:0] imem_addr,
   input  logic [15:0]       imem_data,
   output logic [DADDR-1:0]  d_addr,
   output logic              d_rd,
   output logic              d_wr,
   output logic [WIDTH-1:0]  d_w_data,
   input  logic [WIDTH-1:0]  d_r_data,
   output logic              retire,
   output logic              halted,
   output logic              err
);

   logic [PCBITS-1:0] r_pc;
   logic [15:0]       r_ir;
   logic [WIDTH-1:0]  r_rf [16];

   logic [3:0]        w_op;
   logic [3:0]        w_ra;
   logic [3:0]        w_rb;
   logic [3:0]        w_rc;
   logic [7:0]        w_imm;
   logic [3:0]        w_rd1_addr;
   logic [WIDTH-1:0]  w_rd1;
   logic [WIDTH-1:0]  w_rd2;
   logic [WIDTH-1:0]  w_alu;
   logic [WIDTH-1:0]  w_wdata;
   logic              w_zero;
   logic              w_pc_clr;
   logic              w_fetch;
   logic              w_jmp;
   logic              w_rf_we;
   logic              w_sel_mem;
   logic              w_sel_imm;
   logic              w_alu_sub;
   logic              w_alu_rb;

   assign w_op  = r_ir[OP_HI:OP_LO];
   assign w_ra  = r_ir[RA_HI:RA_LO];
   assign w_rb  = r_ir[RB_HI:RB_LO];
   assign w_rc  = r_ir[RC_HI:RC_LO];
   assign w_imm = r_ir[IMM_HI:IMM_LO];

   // port 1 reads rb for ALU ops, otherwise ra (store data, zero test)
   assign w_rd1_addr = w_alu_rb ? w_rb : w_ra;
   assign w_rd1      = r_rf[w_rd1_addr];
   assign w_rd2      = r_rf[w_rc];
   assign w_zero     = (w_rd1 == '0);
   assign w_alu      = w_alu_sub ? (w_rd1 - w_rd2) : (w_rd1 + w_rd2);
   assign w_wdata    = w_sel_mem ? d_r_data :
                       w_sel_imm ? WIDTH'(w_imm) : w_alu;

   assign imem_addr = r_pc;
   assign d_addr    = DADDR'(w_imm);
   assign d_w_data  = w_rd1;

   proc6_ctrl u_ctrl (
      .clk       (clk),
      .i_reset   (reset),
      .i_start   (start),
      .i_op      (w_op),
      .i_zero    (w_zero),
      .o_pc_clr  (w_pc_clr),
      .o_fetch   (w_fetch),
      .o_jmp     (w_jmp),
      .o_rf_we   (w_rf_we),
      .o_sel_mem (w_sel_mem),
      .o_sel_imm (w_sel_imm),
      .o_alu_sub (w_alu_sub),
      .o_alu_rb  (w_alu_rb),
      .o_d_rd    (d_rd),
      .o_d_wr    (d_wr),
      .o_retire  (retire),
      .o_halted  (halted),
      .o_err     (err)
   );

   // PC: PC already points past the JMPZ, so the jump undoes that +1
   always_ff @(posedge clk) begin
      if (reset || w_pc_clr)
         r_pc <= '0;
      else if (w_fetch)
         r_pc <= r_pc + PCBITS'(1);
      else if (w_jmp)
         r_pc <= r_pc + PCBITS'($signed(w_imm)) - PCBITS'(1);
   end

   // instruction register loads in FETCH
   always_ff @(posedge clk) begin
      if (reset)        r_ir <= '0;
      else if (w_fetch) r_ir <= imem_data;
   end

   // register file write port; contents are deliberately not reset
   always_ff @(posedge clk) begin
      if (w_rf_we) r_rf[w_ra] <= w_wdata;
   end

endmodule

// File: tb/tb_proc6_core.sv
// Self-checking bench for proc6_core: directed tables, corner
// sequences and random programs against an ISA-level model.
module tb_proc6_core;

   logic        clk = 1'b0;
   logic        reset;
   logic        start;
   logic        start8;
   logic [15:0] imem_addr;
   logic [15:0] imem_data;
   logic [7:0]  d_addr;
   logic        d_rd;
   logic        d_wr;
   logic [15:0] d_w_data;
   logic [15:0] d_r_data;
   logic        retire;
   logic        halted;
   logic        err;

   logic [15:0] imem_addr8;
   logic [15:0] imem_data8;
   logic [7:0]  d_addr8;
   logic        d_rd8;
   logic        d_wr8;
   logic [7:0]  d_w_data8;
   logic [7:0]  d_r_data8;
   logic        retire8;
   logic        halted8;
   logic        err8;

   logic [15:0] imem [256];
   logic [15:0] imem8 [256];
   logic [15:0] dmem [256];

   int checks = 0;
   int fails  = 0;
   int cyc    = 0;
   int rt8    = 0;
   bit prev_ret = 1'b0;
   int          rt_q [$];
   logic [15:0] fa_q [$];
   logic [23:0] st_q [$];
   logic [15:0] st8_q [$];
   logic [23:0] exp_st [$];

   always #5 clk = ~clk;

   assign imem_data  = imem[imem_addr[7:0]];
   assign imem_data8 = imem8[imem_addr8[7:0]];
   assign d_r_data   = dmem[d_addr];
   assign d_r_data8  = 8'h00;

   proc6_core u_dut (
      .clk       (clk),
      .reset     (reset),
      .start     (start),
      .imem_addr (imem_addr),
      .imem_data (imem_data),
      .d_addr    (d_addr),
      .d_rd      (d_rd),
      .d_wr      (d_wr),
      .d_w_data  (d_w_data),
      .d_r_data  (d_r_data),
      .retire    (retire),
      .halted    (halted),
      .err       (err)
   );

   proc6_core #(.WIDTH(8)) u_dut8 (
      .clk       (clk),
      .reset     (reset),
      .start     (start8),
      .imem_addr (imem_addr8),
      .imem_data (imem_data8),
      .d_addr    (d_addr8),
      .d_rd      (d_rd8),
      .d_wr      (d_wr8),
      .d_w_data  (d_w_data8),
      .d_r_data  (d_r_data8),
      .retire    (retire8),
      .halted    (halted8),
      .err       (err8)
   );

   typedef struct {
      logic [3:0]  op;
      logic [7:0]  a;
      logic [7:0]  b;
      logic [15:0] exp;
   } vec_t;

   task automatic chk(input string nm, input logic [31:0] act,
                      input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %0h expected %0h", nm, act, exp);
      end
   endtask

   // sample mid-cycle, advance one edge, then commit any store
   task automatic step();
      logic        w;
      logic [7:0]  a;
      logic [15:0] dt;
      w  = d_wr;
      a  = d_addr;
      dt = d_w_data;
      if (retire) rt_q.push_back(cyc);
      if (prev_ret) fa_q.push_back(imem_addr);
      prev_ret = retire;
      if (d_wr) st_q.push_back({d_addr, d_w_data});
      if (d_wr8) st8_q.push_back({d_addr8, d_w_data8});
      if (retire8) rt8++;
      @(posedge clk);
      #1;
      if (w) dmem[a] = dt;
      cyc++;
   endtask

   task automatic run_prog(input int budget, output int n);
      start = 1'b1;
      step();
      start = 1'b0;
      n = 1;
      while (!halted && n < budget) begin
         step();
         n++;
      end
      chk("run_timeout", {31'd0, !halted}, 32'd0);
   endtask

   task automatic clear_imem();
      for (int i = 0; i < 256; i++) imem[i] = 16'h6000;
   endtask

   // instruction-level interpreter: whole instructions, cycle costs
   task automatic model_run(output int mc, output int mr,
                            output logic me);
      logic [15:0] rg [16];
      logic [15:0] dm [256];
      logic [15:0] pc;
      logic [15:0] ins;
      logic [3:0]  ra;
      logic [3:0]  rb;
      logic [3:0]  rc;
      logic [7:0]  lo;
      for (int i = 0; i < 256; i++) dm[i] = dmem[i];
      for (int i = 0; i < 16; i++) rg[i] = 16'h0;
      exp_st.delete();
      pc = 16'h0;
      mc = 1;
      mr = 0;
      me = 1'b0;
      for (int k = 0; k < 1000; k++) begin
         ins = imem[pc[7:0]];
         ra  = ins[11:8];
         rb  = ins[7:4];
         rc  = ins[3:0];
         lo  = ins[7:0];
         if (ins[15:12] == 4'd6) begin
            mc += 2;
            break;
         end
         if (ins[15:12] > 4'd6) begin
            mc += 2;
            me = 1'b1;
            break;
         end
         mr++;
         mc += 3;
         pc = pc + 16'd1;
         case (ins[15:12])
            4'd0: rg[ra] = dm[lo];
            4'd1: begin
               exp_st.push_back({lo, rg[ra]});
               dm[lo] = rg[ra];
            end
            4'd2: rg[ra] = rg[rb] + rg[rc];
            4'd3: rg[ra] = {8'h00, lo};
            4'd4: rg[ra] = rg[rb] - rg[rc];
            default: begin
               if (rg[ra] == 16'h0) begin
                  pc = pc - 16'd1 + {{8{lo[7]}}, lo};
                  mc += 1;
               end
            end
         endcase
      end
   endtask

   initial begin
      vec_t        tbl [6];
      int          n;
      int          sb;
      int          rb;
      int          fb;
      int          mc;
      int          mr;
      logic        me;
      int          r;
      logic [7:0]  v;

      tbl[0] = '{4'h2, 8'd5,   8'd3,   16'h0008};
      tbl[1] = '{4'h4, 8'd5,   8'd3,   16'h0002};
      tbl[2] = '{4'h4, 8'd3,   8'd5,   16'hFFFE};
      tbl[3] = '{4'h2, 8'd255, 8'd255, 16'h01FE};
      tbl[4] = '{4'h4, 8'd0,   8'd1,   16'hFFFF};
      tbl[5] = '{4'h4, 8'd0,   8'd0,   16'h0000};

      clear_imem();
      for (int i = 0; i < 256; i++) imem8[i] = 16'h6000;
      for (int i = 0; i < 256; i++) dmem[i] = 16'h0;
      reset  = 1'b1;
      start  = 1'b0;
      start8 = 1'b0;
      @(posedge clk);
      #1;
      step();
      step();
      reset = 1'b0;

      chk("rst_halted", {31'd0, halted}, 32'd0);
      chk("rst_retire", {31'd0, retire}, 32'd0);
      chk("rst_d_rd", {31'd0, d_rd}, 32'd0);
      chk("rst_d_wr", {31'd0, d_wr}, 32'd0);
      chk("rst_err", {31'd0, err}, 32'd0);
      chk("rst_imem_addr", {16'd0, imem_addr}, 32'd0);
      step();
      step();
      chk("idle_hold_addr", {16'd0, imem_addr}, 32'd0);

      // MOVI/MOVI/SUB/STORE/HALT
      clear_imem();
      imem[0] = 16'h3105;
      imem[1] = 16'h3203;
      imem[2] = 16'h4312;
      imem[3] = 16'h1310;
      sb = st_q.size();
      rb = rt_q.size();
      run_prog(100, n);
      chk("p1_nstore", st_q.size() - sb, 32'd1);
      if (st_q.size() > sb)
         chk("p1_store", {8'd0, st_q[sb]}, {8'd0, 8'h10, 16'h0002});
      chk("p1_retires", rt_q.size() - rb, 32'd4);
      chk("p1_halt_edge", n, 32'd15);
      chk("p1_err", {31'd0, err}, 32'd0);

      // table of ALU results seen through a STORE
      for (int t = 0; t < 6; t++) begin
         clear_imem();
         imem[0] = {8'h31, tbl[t].a};
         imem[1] = {8'h32, tbl[t].b};
         imem[2] = {tbl[t].op, 12'h312};
         imem[3] = 16'h1320;
         sb = st_q.size();
         run_prog(100, n);
         chk("tbl_nstore", st_q.size() - sb, 32'd1);
         if (st_q.size() > sb)
            chk($sformatf("tbl%0d_store", t), {8'd0, st_q[sb]},
                {8'd0, 8'h20, tbl[t].exp});
      end

      // LOAD 0xFFFF then doubled: wrap-around
      clear_imem();
      dmem[0] = 16'hFFFF;
      imem[0] = 16'h0100;
      imem[1] = 16'h2211;
      imem[2] = 16'h1201;
      sb = st_q.size();
      run_prog(100, n);
      chk("ld_nstore", st_q.size() - sb, 32'd1);
      if (st_q.size() > sb)
         chk("ld_add_wrap", {8'd0, st_q[sb]}, {8'd0, 8'h01, 16'hFFFE});

      // JMPZ at address 2, taken (R0=0) and not taken (R0=1)
      for (int t = 0; t < 2; t++) begin
         clear_imem();
         imem[0] = (t == 0) ? 16'h3000 : 16'h3001;
         imem[1] = 16'h3500;
         imem[2] = 16'h5003;
         imem[3] = 16'h1030;
         imem[5] = 16'h1031;
         sb = st_q.size();
         rb = rt_q.size();
         fb = fa_q.size();
         run_prog(100, n);
         chk("jz_retires", rt_q.size() - rb, 32'd4);
         if (rt_q.size() >= rb + 3 && fa_q.size() >= fb + 3) begin
            chk("jz_gap", rt_q[rb+2] - rt_q[rb+1], (t == 0) ? 4 : 3);
            chk("jz_next_pc", {16'd0, fa_q[fb+2]}, (t == 0) ? 5 : 3);
         end
         else chk("jz_trace_len", 32'd0, 32'd1);
         if (st_q.size() > sb)
            chk("jz_store_addr", {24'd0, st_q[sb][23:16]},
                (t == 0) ? 32'h31 : 32'h30);
         chk("jz_edges", n, (t == 0) ? 16 : 15);
      end

      // illegal opcode, then restart clears err
      clear_imem();
      imem[0] = 16'hF000;
      run_prog(50, n);
      chk("ill_err", {31'd0, err}, 32'd1);
      chk("ill_edges", n, 32'd3);
      start = 1'b1;
      step();
      start = 1'b0;
      chk("restart_addr", {16'd0, imem_addr}, 32'd0);
      chk("restart_err", {31'd0, err}, 32'd0);
      chk("restart_halted", {31'd0, halted}, 32'd0);
      n = 0;
      while (!halted && n < 50) begin
         step();
         n++;
      end
      chk("ill2_timeout", {31'd0, !halted}, 32'd0);

      // reset landing on the STORE cycle
      clear_imem();
      imem[0] = 16'h3012;
      imem[1] = 16'h1040;
      dmem[8'h40] = 16'hDEAD;
      start = 1'b1;
      step();
      start = 1'b0;
      for (int i = 0; i < 5; i++) step();
      chk("rs_pre_wr", {31'd0, d_wr}, 32'd1);
      chk("rs_pre_addr", {24'd0, d_addr}, 32'h40);
      reset = 1'b1;
      #1;
      chk("rs_wr_gated", {31'd0, d_wr}, 32'd0);
      step();
      chk("rs_addr", {16'd0, imem_addr}, 32'd0);
      chk("rs_halted", {31'd0, halted}, 32'd0);
      chk("rs_mem", {16'd0, dmem[8'h40]}, 32'h0000DEAD);
      reset = 1'b0;
      step();

      // 8-bit instance: 0 - 0xAB wraps to 0x55
      imem8[0] = 16'h31AB;
      imem8[1] = 16'h3000;
      imem8[2] = 16'h4201;
      imem8[3] = 16'h1202;
      rt8 = 0;
      start8 = 1'b1;
      step();
      start8 = 1'b0;
      n = 1;
      while (!halted8 && n < 100) begin
         step();
         n++;
      end
      chk("w8_timeout", {31'd0, !halted8}, 32'd0);
      chk("w8_nstore", st8_q.size(), 32'd1);
      if (st8_q.size() > 0)
         chk("w8_store", {16'd0, st8_q[0]}, 32'h0255);
      chk("w8_retires", rt8, 32'd4);
      chk("w8_err", {31'd0, err8}, 32'd0);
      chk("w8_d_rd", {31'd0, d_rd8}, 32'd0);

      // random programs against the instruction-level model
      for (int i = 0; i < 256; i++) dmem[i] = 16'($urandom);
      for (int p = 0; p < 25; p++) begin
         clear_imem();
         for (int k = 0; k < 16; k++) begin
            v = ($urandom_range(3) == 0) ? 8'h00 : 8'($urandom);
            imem[k] = {4'h3, 4'(k), v};
         end
         for (int k = 16; k < 36; k++) begin
            r = $urandom_range(99);
            v = 8'($urandom);
            if (r < 15)      imem[k] = {4'h0, 4'($urandom), v};
            else if (r < 30) imem[k] = {4'h1, 4'($urandom), v};
            else if (r < 48) imem[k] = {4'h2, 12'($urandom)};
            else if (r < 60) imem[k] = {4'h3, 4'($urandom), v};
            else if (r < 78) imem[k] = {4'h4, 12'($urandom)};
            else if (r < 97)
               imem[k] = {4'h5, 4'($urandom),
                          8'($urandom_range(6, 1))};
            else
               imem[k] = {4'($urandom_range(15, 7)), 12'($urandom)};
         end
         model_run(mc, mr, me);
         sb = st_q.size();
         rb = rt_q.size();
         run_prog(600, n);
         chk("rnd_cycles", n, mc);
         chk("rnd_retires", rt_q.size() - rb, mr);
         chk("rnd_err", {31'd0, err}, {31'd0, me});
         chk("rnd_nstore", st_q.size() - sb, exp_st.size());
         for (int k = 0; k < exp_st.size(); k++)
            if (sb + k < st_q.size())
               chk("rnd_store", {8'd0, st_q[sb+k]}, {8'd0, exp_st[k]});
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
      $finish;
   end

endmodule

// File: doc/proc6_core.md
PROC6_CORE -- requirements
Module: proc6_core

Interface
REQ-001 Parameter WIDTH, default 16: datapath, register-file and data-memory word width (WIDTH >= 8).
REQ-002 Parameter PCBITS, default 16: program-counter and instruction-address width.
REQ-003 Parameter DADDR, fixed 8: data-memory address width (matches the instruction d field).
REQ-004 clk  in  1  single clock; all state changes on rising edge.
REQ-005 reset  in  1  synchronous, active-high reset.
REQ-006 start  in  1  launches execution from address 0 when the core is in IDLE or HALT.
REQ-007 imem_addr  out  PCBITS  instruction address (= PC).
REQ-008 imem_data  in  16  instruction word, combinational read.
REQ-009 d_addr  out  DADDR  data-memory address.
REQ-010 d_rd  out  1  data-memory read enable.
REQ-011 d_wr  out  1  data-memory write enable.
REQ-012 d_w_data  out  WIDTH  data-memory write data.
REQ-013 d_r_data  in  WIDTH  data-memory read data, combinational.
REQ-014 retire  out  1  one-cycle pulse in the final cycle of each completed instruction.
REQ-015 halted  out  1  core is in HALT.
REQ-016 err  out  1  halt was caused by an illegal opcode.

Function
REQ-017 Instruction format: op[15:12], ra[11:8], rb[7:4], rc[3:0]; d and C are [7:0]; the jump offset is [7:0], signed.
REQ-018 Opcodes: 0 LOAD ra=D[d]; 1 STORE D[d]=ra; 2 ADD ra=rb+rc; 3 MOVI ra=zext(C); 4 SUB ra=rb-rc; 5 JMPZ ra,off; 6 HALT; 7-15 illegal.
REQ-019 States: IDLE, FETCH, DECODE, LOAD, STORE, ADD, MOVI, SUB, JMPZ, JMP, HALT.
REQ-020 IDLE/HALT with start=1: PC<=0, err<=0, next state FETCH; start is ignored in all other states.
REQ-021 FETCH: IR<=imem_data, PC<=PC+1 modulo 2^PCBITS, next state DECODE.
REQ-022 DECODE: next state is the execute state selected by op; op 6 goes to HALT with err=0; ops 7-15 go to HALT with err<=1.
REQ-023 LOAD: d_rd=1 and d_addr=d; ra<=d_r_data at the clock edge.
REQ-024 STORE: d_wr=1, d_addr=d, d_w_data=R[ra] for exactly one cycle.
REQ-025 ADD/SUB: the result is modulo 2^WIDTH (wrap-around) with no flags; MOVI zero-extends C to WIDTH.
REQ-026 JMPZ: if R[ra]==0, next state is JMP, else FETCH.
REQ-027 JMP: PC<=PC+sext(off)-1 modulo 2^PCBITS, so the target is the JMPZ instruction's address plus off.
REQ-028 All execute states return to FETCH.
REQ-029 retire=1 in LOAD, STORE, ADD, MOVI, SUB, JMP, and in JMPZ only when the jump is not taken.
REQ-030 Latency: 3 cycles per instruction; 4 cycles for a taken JMPZ.
REQ-031 Register file: 16 x WIDTH, two combinational read ports, one synchronous write port.
REQ-032 Register file: at most one write per cycle, only in the LOAD, ADD, MOVI and SUB states.
REQ-033 Register file: a read of the register being written returns the old value in the same cycle.
REQ-034 d_rd=0 and d_wr=0 in every state not named in REQ-023/024.
REQ-035 A JMPZ to itself with R[ra]==0 loops indefinitely; this is legal and not an error.

Reset
REQ-036 With reset=1 at an edge: state<=IDLE, PC<=0, IR<=0, err<=0.
REQ-037 Outputs after reset: halted=0, retire=0, d_rd=0, d_wr=0, imem_addr=0.
REQ-038 d_wr and d_rd are gated by !reset, so a reset asserted in the STORE state causes no memory write.
REQ-039 Register-file contents are not reset.

Structure
REQ-040 Package proc6_pkg holds the opcode enum, the state enum and the instruction-field bit-position constants.
REQ-041 The controller FSM is the single sub-module proc6_ctrl; the datapath (PC, IR, register file, ALU) lives in proc6_core.

Verification
REQ-042 MOVI R1,#5; MOVI R2,#3; SUB R3,R1,R2; STORE D[0x10],R3; HALT, then start -> d_wr=1 with d_addr=0x10 and d_w_data=0x0002; 4 retire pulses; halted=1 on the 15th edge after start; err=0.
REQ-043 D[0]=0xFFFF; LOAD R1,D[0]; ADD R2,R1,R1; STORE D[1],R2 -> d_w_data=0xFFFE (wrap).
REQ-044 JMPZ R0,+3 at address 2 with R0=0 -> next FETCH imem_addr=5, 4-cycle instruction; with R0=1 -> next imem_addr=3.
REQ-045 Instruction 0xF000 -> halted=1, err=1; start -> imem_addr=0 in FETCH and err=0.
REQ-046 Reset asserted during the STORE state -> d_wr=0 in that cycle; state IDLE and imem_addr=0 next cycle.
REQ-047 With WIDTH=8: MOVI R1,#0xAB; MOVI R0,#0; SUB R2,R0,R1; STORE -> d_w_data=0x55.
